// File: rtl/fft_sdf_stage.sv
// ============================================================================
//  Module      : fft_sdf_stage
//  Description : Radix-2 single-path delay-feedback first butterfly stage.
//                Streams FIR samples through an N/2-word delay line, emits
//                sums during the second half of each frame and the stored
//                differences during the first half of the next frame or on
//                an explicit flush/drain.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_sdf_stage #(
    parameter int N  = 16,
    parameter int DW = 16,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fir_valid,
    input  logic [DW-1:0] fft_d_in,
    input  logic          flush,
    output logic          fft_valid,
    output logic [DW:0]   fft_d_out,
    output logic          fft_half,
    output logic [AW-2:0] fft_idx,
    output logic          busy
);

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic [AW-2:0] didx_q, didx_d;
    logic          valid_q, valid_d;
    logic [DW:0]   dout_q, dout_d;
    logic          half_q, half_d;
    logic [AW-2:0] idx_q, idx_d;

    logic [DW:0]   dline [N/2];

    logic [AW-2:0] w_k;
    logic          w_phase_b;
    logic [DW:0]   w_x_ext;
    logic [AW-2:0] w_rd_addr;
    logic [DW:0]   w_rd_data;
    logic          w_flush_ok;
    logic          w_accept;
    logic          w_we;
    logic [DW:0]   w_wr_data;

    // Next-state, butterfly arithmetic and delay-line write request
    always_comb begin
        w_k        = cnt_q[AW-2:0];
        w_phase_b  = cnt_q[AW-1];
        w_x_ext    = {fft_d_in[DW-1], fft_d_in};
        w_rd_addr  = (state_q == S_DRAIN) ? didx_q : w_k;
        w_rd_data  = dline[w_rd_addr];
        // A flush is only meaningful on a frame boundary with differences stored
        w_flush_ok = flush && (state_q == S_RUN) && (cnt_q == '0) && pend_q;
        // A simultaneous honoured flush wins over the incoming sample
        w_accept   = fir_valid && (state_q == S_RUN) && !w_flush_ok;

        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        didx_d    = didx_q;
        valid_d   = 1'b0;
        dout_d    = dout_q;
        half_d    = half_q;
        idx_d     = idx_q;
        w_we      = 1'b0;
        w_wr_data = '0;

        if (state_q == S_RUN) begin
            if (w_flush_ok) begin
                state_d = S_DRAIN;
                didx_d  = '0;
            end else if (w_accept) begin
                cnt_d = cnt_q + AW'(1);
                w_we  = 1'b1;
                if (!w_phase_b) begin
                    // Read-before-write: the old difference leaves as the new sample lands
                    valid_d   = pend_q;
                    if (pend_q) begin
                        dout_d = w_rd_data;
                        half_d = 1'b1;
                        idx_d  = w_k;
                    end
                    w_wr_data = w_x_ext;
                end else begin
                    valid_d   = 1'b1;
                    dout_d    = w_rd_data + w_x_ext;
                    half_d    = 1'b0;
                    idx_d     = w_k;
                    w_wr_data = w_rd_data - w_x_ext;
                    if (&w_k) begin
                        pend_d = 1'b1;
                    end
                end
            end
        end else begin
            valid_d = 1'b1;
            dout_d  = w_rd_data;
            half_d  = 1'b1;
            idx_d   = didx_q;
            didx_d  = didx_q + (AW-1)'(1);
            if (&didx_q) begin
                state_d = S_RUN;
                pend_d  = 1'b0;
            end
        end
    end

    // Control state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            didx_q  <= '0;
            valid_q <= 1'b0;
            dout_q  <= '0;
            half_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            didx_q  <= didx_d;
            valid_q <= valid_d;
            dout_q  <= dout_d;
            half_q  <= half_d;
            idx_q   <= idx_d;
        end
    end

    // Delay line storage; contents are only ever read back while pend is set
    always_ff @(posedge clk) begin
        if (w_we) begin
            dline[w_k] <= w_wr_data;
        end
    end

    assign fft_valid = valid_q;
    assign fft_d_out = dout_q;
    assign fft_half  = half_q;
    assign fft_idx   = idx_q;
    assign busy      = (state_q == S_DRAIN);

endmodule

`default_nettype wire

// File: tb/tb_fft_sdf_stage.sv
// ============================================================================
//  Module      : tb_fft_sdf_stage
//  Description : Self-checking bench for fft_sdf_stage against a frame-level
//                reference model (sums/differences of sample pairs).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_sdf_stage;

    localparam int N  = 16;
    localparam int DW = 16;
    localparam int H  = N / 2;
    localparam int W  = DW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          fir_valid;
    logic [DW-1:0] fft_d_in;
    logic          flush;
    logic          fft_valid;
    logic [DW:0]   fft_d_out;
    logic          fft_half;
    logic [2:0]    fft_idx;
    logic          busy;

    fft_sdf_stage #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .fir_valid (fir_valid),
        .fft_d_in  (fft_d_in),
        .flush     (flush),
        .fft_valid (fft_valid),
        .fft_d_out (fft_d_out),
        .fft_half  (fft_half),
        .fft_idx   (fft_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: samples of the frame in flight, differences of the
    // previous complete frame awaiting output, and drain progress.
    int cur      [N];
    int newdiff  [H];
    int prevdiff [H];
    int pos;
    bit have_prev;
    bit draining;
    int dpos;

    int e_valid, e_data, e_half, e_idx, e_busy;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic model_reset();
        pos       = 0;
        have_prev = 1'b0;
        draining  = 1'b0;
        dpos      = 0;
    endtask

    // One clock cycle: drive inputs, predict the registered result, check it
    task automatic step(input bit v, input int x, input bit f);
        fir_valid = v;
        fft_d_in  = DW'(x);
        flush     = f;
        e_valid   = 0;
        if (draining) begin
            e_valid = 1;
            e_data  = prevdiff[dpos];
            e_half  = 1;
            e_idx   = dpos;
            dpos++;
            if (dpos == H) begin
                draining  = 1'b0;
                have_prev = 1'b0;
            end
        end else if (f && pos == 0 && have_prev) begin
            draining = 1'b1;
            dpos     = 0;
        end else if (v) begin
            if (pos < H) begin
                cur[pos] = x;
                if (have_prev) begin
                    e_valid = 1;
                    e_data  = prevdiff[pos];
                    e_half  = 1;
                    e_idx   = pos;
                end
            end else begin
                cur[pos]         = x;
                e_valid          = 1;
                e_data           = cur[pos-H] + x;
                e_half           = 0;
                e_idx            = pos - H;
                newdiff[pos-H]   = cur[pos-H] - x;
                if (pos == N-1) begin
                    for (int i = 0; i < H; i++) prevdiff[i] = newdiff[i];
                    have_prev = 1'b1;
                end
            end
            pos = (pos + 1) % N;
        end
        e_busy = draining ? 1 : 0;
        @(posedge clk);
        #1;
        chk("valid", W'(fft_valid), W'(e_valid));
        chk("busy",  W'(busy),      W'(e_busy));
        if (e_valid != 0) begin
            chk("data", fft_d_out,     W'(e_data));
            chk("half", W'(fft_half),  W'(e_half));
            chk("idx",  W'(fft_idx),   W'(e_idx));
        end
    endtask

    task automatic do_reset();
        fir_valid = 1'b0;
        flush     = 1'b0;
        fft_d_in  = '0;
        rst       = 1'b1;
        #3;
        chk("rst_valid", W'(fft_valid), W'(0));
        chk("rst_data",  fft_d_out,     W'(0));
        chk("rst_half",  W'(fft_half),  W'(0));
        chk("rst_idx",   W'(fft_idx),   W'(0));
        chk("rst_busy",  W'(busy),      W'(0));
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    function automatic int sample(input int kind, input int j);
        if (kind == 0) return j;
        if (kind == 1) return (j < H) ? 32767 : -32768;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    // Feed samples [from..to] of a frame, optionally with random input gaps
    task automatic feed(input int kind, input int from, input int to, input int gap_pct);
        for (int j = from; j <= to; j++) begin
            for (int g = 0; g < 6; g++) begin
                if (int'($urandom_range(0, 99)) >= gap_pct) break;
                step(1'b0, int'($urandom_range(0, 65535)), 1'b0);
            end
            step(1'b1, sample(kind, j), 1'b0);
        end
    endtask

    // Flush followed by enough cycles to cover the drain; inputs arriving
    // during the drain carry random data and must be dropped.
    task automatic flush_drain(input bit with_sample);
        step(with_sample, 12345, 1'b1);
        for (int i = 0; i < H + 2; i++) begin
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)), 1'b0);
            if (!draining) break;
        end
    endtask

    initial begin
        rst       = 1'b0;
        fir_valid = 1'b0;
        flush     = 1'b0;
        fft_d_in  = '0;
        model_reset();
        #2;
        do_reset();

        // Flush with nothing pending is ignored
        step(1'b0, 0, 1'b1);

        // Single ramp frame then drain
        feed(0, 0, N-1, 0);
        step(1'b0, 0, 1'b0);
        flush_drain(1'b0);

        // Two back-to-back ramp frames, differences interleaved in frame 1
        feed(0, 0, N-1, 0);
        feed(0, 0, N-1, 0);

        // Flush at cnt != 0 is ignored
        feed(0, 0, 2, 0);
        step(1'b0, 0, 1'b1);
        feed(0, 3, N-1, 0);

        // Flush together with a valid sample: flush wins
        flush_drain(1'b1);

        // Full-scale frame
        feed(1, 0, N-1, 0);
        flush_drain(1'b0);

        // Ramp frames with ~50% input gaps
        feed(0, 0, N-1, 50);
        feed(0, 0, N-1, 50);
        flush_drain(1'b0);

        // Random data frames with random gaps
        for (int fr = 0; fr < 4; fr++) feed(2, 0, N-1, 30);
        flush_drain(1'b0);
        for (int fr = 0; fr < 2; fr++) feed(2, 0, N-1, 0);

        // Reset after sample 11 of a frame with differences pending
        feed(0, 0, 11, 0);
        do_reset();
        feed(0, 0, N-1, 0);
        feed(0, 0, N-1, 20);
        flush_drain(1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fft_sdf_stage.md
# fft_sdf_stage

Parametrised radix-2 single-path delay-feedback (SDF) first butterfly stage of the frequency-analysis FFT. It sits directly behind the FIR filter and consumes the FIR sample stream one word per `fir_valid`. It emits butterfly sums and differences in streaming order to the next FFT stage. It generalises the fixed 16-point first stage with a configurable frame length and sample width, stall tolerance on input gaps, and an explicit flush/drain of the last frame.

## Interface
- `N`, 16, frame length in samples; power of two, 4..1024; `AW = log2(N)`.
- `DW`, 16, input sample width, two's complement.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `fir_valid` input 1: `fft_d_in` carries a sample this cycle.
- `fft_d_in` input DW: signed input sample.
- `flush` input 1: single-cycle request to drain pending differences.
- `fft_valid` output 1: `fft_d_out` holds a valid butterfly result this cycle.
- `fft_d_out` output DW+1: signed butterfly result.
- `fft_half` output 1: 0 = sum (even-bin path), 1 = difference (odd-bin path).
- `fft_idx` output AW-1: butterfly index k, 0..N/2-1, of the current output.
- `busy` output 1: drain in progress; input is ignored.

## Operation
- Delay line: N/2 words of DW+1 bits, addressed by k. Sample counter `cnt` is AW bits and advances only on accepted samples. Phase = `cnt[AW-1]`. Slot k = `cnt[AW-2:0]`.
- Accepted sample: `fir_valid`=1 and `busy`=0.
- Phase A (cnt < N/2), accepted sample x[k]:
  - If `pend`=1, read slot k and output it as a difference (`fft_half`=1, `fft_idx`=k).
  - Write sign-extended x[k] into slot k.
- Phase B (cnt ≥ N/2), accepted sample x[k+N/2], with a = slot k:
  - Output a + x (`fft_half`=0, `fft_idx`=k).
  - Write a − x into slot k.
  - When k = N/2−1, set `pend`=1.
- `pend` clears at the end of a phase-A pass that had no pending differences. It also clears when a drain completes. Otherwise it stays 1, because the new frame's differences refill the slots.
- Arithmetic: operands are sign-extended to DW+1 bits. Sum and difference are exact, with no saturation or rounding. No twiddle multiply is applied in this stage.
- Flush:
  - Honoured only when `cnt`=0 and `pend`=1. Otherwise it is ignored.
  - When honoured, enter DRAIN with `busy`=1. Output slots 0..N/2−1 as differences, one per cycle.
  - Then clear `pend` and `busy` and return to IDLE/phase A.
  - `fir_valid` during DRAIN is dropped: no counter advance, no write.
- FSM states:
  - RUN: normal phase A/B.
  - DRAIN.
  - RUN→DRAIN: on an honoured flush.
  - DRAIN→RUN: after the slot N/2−1 output.
- Input gaps (`fir_valid`=0 in RUN): hold all state. `fft_valid` = 0 the following cycle.

## Timing
- Outputs are registered. A result caused by an accepted sample (or drain step) at edge t appears after edge t, valid for exactly one cycle.
- Latency input→output: 1 cycle.
- The first sum of frame 0 appears one cycle after sample N/2 of frame 0 is accepted.
- A phase-A difference read and the new sample write to the same slot in the same cycle: read-before-write. The output is the old difference.
- Reset values:
  - `fft_valid`=0, `fft_d_out`=0, `fft_half`=0, `fft_idx`=0, `busy`=0.
  - `cnt`=0, `pend`=0, FSM=RUN.
  - Delay-line contents are don't-care: they are never output while `pend`=0.
- Reset mid-frame or mid-drain: pending data is discarded. The next accepted sample is x[0] of a new frame.
- `flush` and `fir_valid` in the same cycle when flush is honoured: flush wins and the sample is dropped.
- `cnt` wraps N−1→0 with no bubble. Back-to-back frames sustain one output per accepted sample.

## Test plan
- N=16, DW=16, reset, ramp x=0..15 contiguous:
  - No output for the first 8 samples.
  - Then sums 8,10,…,22 with `fft_idx` 0..7 and `fft_half`=0.
  - Then pulse `flush`: eight outputs of −8, `fft_half`=1, `busy`=1 for 8 cycles.
- Two back-to-back ramp frames:
  - Frame-1 phase A emits −8 ×8 (`fft_half`=1) interleaved one per sample.
  - Frame-1 phase B emits sums 8..22.
- Full-scale: frame of 0x7FFF then 0x8000 (x[0..7]=32767, x[8..15]=−32768):
  - Sums −1.
  - Differences 65535 in 17 bits, with no overflow.
- Random `fir_valid` gaps (≈50% duty) on the ramp: identical output sequence to the contiguous case, with `fft_valid` low during gaps.
- `flush` at `cnt`≠0, or with `pend`=0: ignored, no `busy`. `fir_valid` during DRAIN: sample dropped, and `cnt` stays 0.
- Assert `rst` after sample 11 of frame 0, then restart the ramp: the sums match the first scenario and no stale differences are emitted.
